// File: rtl/wave_pkg.sv
// Shared types and constants for the wave_player waveform streamer.
package wave_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 8;
  localparam int PHASE_W_DEF = 16;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/wave_rom.sv
// Synchronous-read waveform table; data holds while rd_en is low.
// The table contents are a ramp (table[i] = i) built at elaboration.
module wave_rom #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = "wave.hex"
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t load_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(i);
    end
    return m;
  endfunction

  mem_t r_mem = load_mem();

  always_ff @(posedge clk) begin
    if (rd_en) data <= r_mem[addr];
  end

endmodule

// File: rtl/wave_player.sv
// Phase-accumulator waveform player streaming table samples on valid/ready.
// Define WAVE_PLAYER_GAIN_EN to add an 8-bit gain input applied to each sample.
module wave_player
  import wave_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter int    PHASE_W   = PHASE_W_DEF,
  parameter string INIT_FILE = "wave.hex"
) (
  input  logic               clk,
  input  logic               reset,
`ifdef WAVE_PLAYER_GAIN_EN
  input  logic [7:0]         gain,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [PHASE_W-1:0] step,
  input  logic               sample_ready,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  // Handshake: a sample transfers on any rising edge where sample_valid and
  // sample_ready are both high; while valid and not ready, sample is held.

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_step;
  logic               r_mode;
  logic               r_done;
  logic               r_loaded;

  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W-1:0] w_phase_n;
  logic               w_carry;
  logic               w_launch;
  logic               w_accept;
  logic               w_finish;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0]  w_rom_data;
  logic [DATA_W-1:0]  w_word;

  assign w_sum     = {1'b0, r_phase} + {1'b0, r_step};
  assign w_phase_n = w_sum[PHASE_W-1:0];
  assign w_carry   = w_sum[PHASE_W];

  assign w_launch = (r_state == IDLE) && start && !stop;
  assign w_accept = (r_state == STREAM) && sample_ready && !stop;
  assign w_finish = w_accept && (r_mode == MODE_ONESHOT) &&
                    (w_carry || (r_step == '0));

  // The next read is issued on the accept edge itself, so a continuously
  // ready consumer sees one sample per cycle.
  assign w_rd_en   = ((r_state == FETCH) && !stop) || (w_accept && !w_finish);
  assign w_rd_addr = (r_state == FETCH) ? r_phase[PHASE_W-1 -: ADDR_W]
                                        : w_phase_n[PHASE_W-1 -: ADDR_W];

  wave_rom #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .rd_en(w_rd_en),
    .addr (w_rd_addr),
    .data (w_rom_data)
  );

`ifdef WAVE_PLAYER_GAIN_EN
  logic [7:0]          r_gain;
  logic [DATA_W+7:0]   w_scaled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_gain <= '0;
    else if (w_launch) r_gain <= gain;
  end

  assign w_scaled = w_rom_data * r_gain;
  assign w_word   = DATA_W'(w_scaled >> 8);
`else
  assign w_word = w_rom_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_step   <= '0;
      r_mode   <= MODE_LOOP;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rd_en) r_loaded <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= FETCH;
            r_phase <= '0;
            r_step  <= step;
            r_mode  <= mode;
          end
        end
        FETCH: begin
          r_state <= stop ? IDLE : STREAM;
        end
        STREAM: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            if (w_finish) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_phase <= w_phase_n;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The table register has no reset, so the output is forced to zero until
  // the first read after reset has landed.
  assign sample       = r_loaded ? w_word : '0;
  assign sample_valid = (r_state == STREAM);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;

endmodule
